// File: rtl/osd_stm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osd_stm_pkg                                                              |
// | Shared types and constants for the STM trace arbiter.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package osd_stm_pkg;

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] value;
    } trace_event_t;

    localparam logic [15:0] OVF_ID_DEFAULT = 16'h0001;
    localparam int          OVF_CNT_LSB    = 32;
    localparam int          OVF_SRC_LSB    = 0;

    function automatic logic [63:0] ovf_record(input logic [15:0] cnt, input logic [7:0] src);
        logic [63:0] v;
        v                      = '0;
        v[OVF_CNT_LSB +: 16]   = cnt;
        v[OVF_SRC_LSB +: 8]    = src;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/osd_trace_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osd_trace_fifo                                                           |
// | Per-source synchronous event FIFO; push and pop may coincide when full.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module osd_trace_fifo
    import osd_stm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  trace_event_t din,
    output trace_event_t dout,
    output logic         full,
    output logic         empty,
    output logic         empty_next
);

    localparam int c_AW = $clog2(DEPTH);

    trace_event_t    r_mem [DEPTH];
    logic [c_AW:0]   r_wr_ptr;
    logic [c_AW:0]   r_rd_ptr;
    logic [c_AW:0]   w_wr_ptr_nxt;
    logic [c_AW:0]   w_rd_ptr_nxt;

    // Extra MSB on each pointer distinguishes full from empty.
    assign w_wr_ptr_nxt = r_wr_ptr + {{c_AW{1'b0}}, push};
    assign w_rd_ptr_nxt = r_rd_ptr + {{c_AW{1'b0}}, pop};

    assign empty      = (r_wr_ptr == r_rd_ptr);
    assign full       = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty_next = (w_wr_ptr_nxt == w_rd_ptr_nxt);
    assign dout       = r_mem[r_rd_ptr[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/osd_stm_trace_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | osd_stm_trace_arbiter                                                    |
// | Round-robin merge of per-source trace FIFOs onto one STM event port,     |
// | with in-band overflow records carrying per-source drop counts.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module osd_stm_trace_arbiter
    import osd_stm_pkg::*;
#(
    parameter int          NUM_SRC    = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] OVF_ID     = OVF_ID_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      src_enable,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [16*NUM_SRC-1:0]   src_id,
    input  logic [64*NUM_SRC-1:0]   src_value,
    output logic                    trace_valid,
    output logic [15:0]             trace_id,
    output logic [63:0]             trace_value,
    output logic                    busy
);

    localparam int c_PTR_W = $clog2(NUM_SRC);

    trace_event_t               w_fifo_dout [NUM_SRC];
    logic [NUM_SRC-1:0]         w_full;
    logic [NUM_SRC-1:0]         w_empty;
    logic [NUM_SRC-1:0]         w_empty_next;
    logic [NUM_SRC-1:0]         w_push;
    logic [NUM_SRC-1:0]         w_pop;
    logic [NUM_SRC-1:0]         w_drop;
    logic [NUM_SRC-1:0]         w_ovf_clear;
    logic [NUM_SRC-1:0]         w_req;
    logic [NUM_SRC-1:0]         w_ovf_pending_nxt;
    logic [NUM_SRC-1:0]         r_ovf_pending;
    logic [NUM_SRC-1:0][15:0]   r_drop_cnt;
    logic [c_PTR_W-1:0]         r_ptr;
    logic [c_PTR_W-1:0]         w_grant_idx;
    logic [c_PTR_W:0]           w_cand;
    logic                       w_grant;
    logic                       r_trace_valid;
    logic [15:0]                r_trace_id;
    logic [63:0]                r_trace_value;
    logic                       r_busy;

    assign w_req = ~w_empty | r_ovf_pending;

    // Search begins one past the last winner so every requester is served within NUM_SRC cycles.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = r_ptr;
        w_cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_cand = {1'b0, r_ptr} + (c_PTR_W+1)'(k);
            if (w_cand >= (c_PTR_W+1)'(NUM_SRC)) begin
                w_cand = w_cand - (c_PTR_W+1)'(NUM_SRC);
            end
            if (!w_grant && w_req[w_cand[c_PTR_W-1:0]]) begin
                w_grant     = 1'b1;
                w_grant_idx = w_cand[c_PTR_W-1:0];
            end
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic         w_sel;
        logic         w_en_evt;
        trace_event_t w_din;

        assign w_sel          = w_grant && (w_grant_idx == c_PTR_W'(i));
        assign w_pop[i]       = w_sel & ~w_empty[i];
        assign w_ovf_clear[i] = w_sel & w_empty[i];
        assign w_en_evt       = src_valid[i] & src_enable[i];
        // A clearing grant reopens the source in the same cycle.
        assign w_push[i]      = w_en_evt & ~(r_ovf_pending[i] & ~w_ovf_clear[i]) &
                                (~w_full[i] | w_pop[i]);
        assign w_drop[i]      = w_en_evt & ~w_push[i];
        assign w_din          = '{id: src_id[16*i +: 16], value: src_value[64*i +: 64]};

        osd_trace_fifo #(
            .DEPTH      (FIFO_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push       (w_push[i]),
            .pop        (w_pop[i]),
            .din        (w_din),
            .dout       (w_fifo_dout[i]),
            .full       (w_full[i]),
            .empty      (w_empty[i]),
            .empty_next (w_empty_next[i])
        );
    end

    assign w_ovf_pending_nxt = (r_ovf_pending & ~w_ovf_clear) | w_drop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf_pending <= '0;
            r_drop_cnt    <= '0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_drop[i]) begin
                    r_ovf_pending[i] <= 1'b1;
                    if (r_drop_cnt[i] != 16'hFFFF) begin
                        r_drop_cnt[i] <= r_drop_cnt[i] + 16'd1;
                    end
                end else if (w_ovf_clear[i]) begin
                    r_ovf_pending[i] <= 1'b0;
                    r_drop_cnt[i]    <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr         <= c_PTR_W'(NUM_SRC - 1);
            r_trace_valid <= 1'b0;
            r_trace_id    <= '0;
            r_trace_value <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_trace_valid <= w_grant;
            r_busy        <= |(~w_empty_next | w_ovf_pending_nxt);
            if (w_grant) begin
                r_ptr <= w_grant_idx;
                if (w_empty[w_grant_idx]) begin
                    r_trace_id    <= OVF_ID;
                    r_trace_value <= ovf_record(r_drop_cnt[w_grant_idx], 8'(w_grant_idx));
                end else begin
                    r_trace_id    <= w_fifo_dout[w_grant_idx].id;
                    r_trace_value <= w_fifo_dout[w_grant_idx].value;
                end
            end
        end
    end

    assign trace_valid = r_trace_valid;
    assign trace_id    = r_trace_id;
    assign trace_value = r_trace_value;
    assign busy        = r_busy;

endmodule
`default_nettype wire
